// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and frame constants for the 1-to-4 TDM demultiplexer
package tdm_pkg;
    localparam int SLOTS = 4;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    typedef enum logic {HUNT, LOCKED} state_t;
endpackage

// File: rtl/tdm_demux_1_4_if.sv
// tdm_demux_1_4_if: serial TDM input and demultiplexed frame outputs
interface tdm_demux_1_4_if;
    logic din, in_valid, sync;
    logic a, b, c, d, s1, s0, out_valid, locked, sync_err;
    modport master (output din, in_valid, sync,
                    input a, b, c, d, s1, s0, out_valid, locked, sync_err);
    modport slave (input din, in_valid, sync,
                   output a, b, c, d, s1, s0, out_valid, locked, sync_err);
endinterface

// File: rtl/tdm_demux_1_4_slot_cnt.sv
// tdm_slot_cnt: modulo-4 slot index with increment, load-to-1 and clear
module tdm_slot_cnt
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load1_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] cnt_o
);
    logic [SLOT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load1_i ? SLOT_W'(1) : inc_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk)
        cnt_q <= rst ? '0 : cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: locks on the sync marker and demultiplexes 4-slot serial frames
module tdm_demux_1_4
    import tdm_pkg::*;
(
    input logic clk,
    input logic rst,
    tdm_demux_1_4_if.slave bus
);
    state_t state_q, state_d;
    logic [SLOTS-2:0] buf_q, buf_d;
    logic [SLOTS-1:0] frame_q, frame_d;
    logic out_valid_q, out_valid_d, sync_err_q, sync_err_d;
    logic load1, inc;
    logic [SLOT_W-1:0] slot;
    tdm_slot_cnt u_cnt (.clk(clk), .rst(rst), .load1_i(load1), .inc_i(inc), .cnt_o(slot));
    always_comb begin
        state_d = state_q;
        buf_d = buf_q;
        frame_d = frame_q;
        out_valid_d = 1'b0;
        sync_err_d = 1'b0;
        load1 = 1'b0;
        inc = 1'b0;
        if (bus.in_valid) begin
            if (bus.sync) begin
                buf_d[0] = bus.din;
                load1 = 1'b1;
                state_d = LOCKED;
                sync_err_d = (state_q == LOCKED) && (slot != '0);
            end else if (state_q == LOCKED) begin
                inc = 1'b1;
                // slot 3 arrives directly into the frame; slots 0..2 wait in buf
                if (slot == LAST_SLOT) begin
                    frame_d = {bus.din, buf_q};
                    out_valid_d = 1'b1;
                end else begin
                    buf_d[slot] = bus.din;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            buf_q <= '0;
            frame_q <= '0;
            out_valid_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q <= buf_d;
            frame_q <= frame_d;
            out_valid_q <= out_valid_d;
            sync_err_q <= sync_err_d;
        end
    end
    assign bus.a = frame_q[0];
    assign bus.b = frame_q[1];
    assign bus.c = frame_q[2];
    assign bus.d = frame_q[3];
    assign bus.s1 = slot[1];
    assign bus.s0 = slot[0];
    assign bus.out_valid = out_valid_q;
    assign bus.sync_err = sync_err_q;
    assign bus.locked = (state_q == LOCKED);
endmodule

// File: tb/tb_tdm_demux_1_4.sv
// tb_tdm_demux_1_4: random and directed stimulus checked against a frame-level model
module tb_tdm_demux_1_4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    tdm_demux_1_4_if bus ();
    tdm_demux_1_4 dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct packed {
        logic       locked;
        logic [1:0] slot;
        logic       ov;
        logic       err;
        logic [3:0] abcd;
    } exp_t;
    exp_t exp_q[$];

    bit m_locked = 0;
    bit m_part[$];
    logic [3:0] m_abcd = '0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // model: a frame is the list of bits accepted since the last sync while locked
    task automatic step(input bit r, input bit v, input bit s, input bit dn);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.in_valid = v;
        bus.sync = s;
        bus.din = dn;
        e = '0;
        if (r) begin
            m_locked = 0;
            m_part.delete();
            m_abcd = '0;
        end else if (v && s) begin
            e.err = m_locked && m_part.size() != 0;
            m_part.delete();
            m_part.push_back(dn);
            m_locked = 1;
        end else if (v && m_locked) begin
            m_part.push_back(dn);
            if (m_part.size() == 4) begin
                m_abcd = {m_part[0], m_part[1], m_part[2], m_part[3]};
                e.ov = 1;
                m_part.delete();
            end
        end
        e.locked = m_locked;
        e.slot = m_locked ? 2'(m_part.size()) : 2'd0;
        e.abcd = m_abcd;
        exp_q.push_back(e);
    endtask

    task automatic frame(input logic [3:0] bits, input int gap);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, i == 0, bits[3-i]);
            for (int g = 0; g < gap; g++) step(0, 0, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("locked", {3'b0, bus.locked}, {3'b0, e.locked});
                chk("slot", {2'b0, bus.s1, bus.s0}, {2'b0, e.slot});
                chk("out_valid", {3'b0, bus.out_valid}, {3'b0, e.ov});
                chk("sync_err", {3'b0, bus.sync_err}, {3'b0, e.err});
                chk("abcd", {bus.a, bus.b, bus.c, bus.d}, e.abcd);
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.sync = 1'b0;
        bus.din = 1'b0;
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        frame(4'b0110, 0);
        frame(4'b1001, 0);
        frame(4'b1101, 3);
        step(0, 1, 1, 1);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 1);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        step(0, 1, 0, 1);
        step(1, 1, 0, 1);
        step(0, 1, 0, 0);
        frame(4'b0011, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        step(0, 1, 0, 0);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 2, 1'($urandom));
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected cycles unchecked, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tdm_demux_1_4.md
TDM_DEMUX_1_4 -- requirements
Module: tdm_demux_1_4

Interface
REQ-001 The block SHALL have no parameters; the frame is fixed at 4 slots of 1 bit each.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 din  input  1  serial TDM data bit.
REQ-005 in_valid  input  1  din/sync qualifier; a bit is accepted only on a cycle where in_valid=1.
REQ-006 sync  input  1  frame marker; meaningful only when in_valid=1; marks din as slot 0.
REQ-007 a  output  1  slot-0 bit of the last completed frame.
REQ-008 b  output  1  slot-1 bit of the last completed frame.
REQ-009 c  output  1  slot-2 bit of the last completed frame.
REQ-010 d  output  1  slot-3 bit of the last completed frame.
REQ-011 s1, s0  output  1 each  slot index expected for the next accepted bit (s1 is MSB).
REQ-012 out_valid  output  1  one-cycle pulse: a, b, c, d were just updated.
REQ-013 locked  output  1  high while the block is in LOCKED.
REQ-014 sync_err  output  1  one-cycle pulse: a partial frame was dropped on resync.

Function
REQ-015 The FSM SHALL have exactly two states: HUNT and LOCKED.
REQ-016 HUNT behaviour:
- Accepted bits with sync=0 SHALL be discarded.
- An accepted bit with sync=1 SHALL be stored as slot 0, set {s1,s0}=1 and move to LOCKED.
REQ-017 LOCKED, sync=0: each accepted bit SHALL be stored into slot {s1,s0}, and {s1,s0} SHALL increment modulo 4 (3 wraps to 0).
REQ-018 Frame completion: when the slot-3 bit is accepted with sync=0:
- a..d SHALL load all four captured bits on the same edge.
- out_valid SHALL be 1 for exactly the following cycle.
- Latency from the slot-3 bit to out_valid is 1 cycle.
REQ-019 LOCKED, sync=1 with {s1,s0}=0: expected frame boundary; the bit SHALL be stored as slot 0 and {s1,s0} SHALL become 1, with no error.
REQ-020 LOCKED, sync=1 with {s1,s0}≠0: resync.
- sync_err SHALL pulse for 1 cycle.
- The partial frame SHALL be discarded.
- a..d SHALL be left unchanged.
- din SHALL be stored as slot 0 and {s1,s0} SHALL become 1.
REQ-021 Cycles with in_valid=0 SHALL change no state, slot index or data; sync and din SHALL be ignored on those cycles.
REQ-022 a..d SHALL hold their values between completions; out_valid SHALL be 0 on all other cycles.
REQ-023 sync=1 on a slot-3 bit is a resync per REQ-020: no frame completes and no out_valid pulse occurs.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL enter HUNT and clear a, b, c, d, {s1,s0}, out_valid, locked and sync_err to 0.
REQ-025 rst SHALL override all simultaneous inputs, and any partial frame in progress SHALL be discarded.
REQ-026 After rst falls, the first accepted sync=1 bit SHALL be treated per REQ-016.

Structure
REQ-027 The shared package tdm_pkg SHALL hold the FSM state enum (HUNT, LOCKED) and the constant SLOTS=4.
REQ-028 The 2-bit modulo-4 slot counter (inc, load-to-1, clear) SHALL be a sub-module named tdm_slot_cnt.
REQ-029 All outputs SHALL be driven directly from registers.

Verification
REQ-030 Reset, then frame with sync on bit 0, in_valid=1, din=0,1,1,0 -> cycle after last bit: a=0 b=1 c=1 d=0, out_valid=1 for 1 cycle, locked=1.
REQ-031 Second back-to-back frame din=1,0,0,1 (sync=1 on first bit) -> a=1 b=0 c=0 d=1, no sync_err.
REQ-032 in_valid=0 gaps of 3 cycles inserted between every bit of frame 1,1,0,1 -> result a=1 b=1 c=0 d=1; {s1,s0} frozen during gaps.
REQ-033 sync=1 asserted at slot 2 while LOCKED -> sync_err pulse; a..d keep previous values; {s1,s0}=1 next cycle.
REQ-034 Bits with sync=0 before any sync -> no out_valid, locked=0.
REQ-035 rst asserted mid-frame at slot 2 -> all outputs 0 and HUNT next cycle.
REQ-036 Sync on slot 3 -> sync_err pulse and no out_valid.
